// File: rtl/ppi_pkg.sv
// Shared constants and types for the strobed parallel peripheral interface.
package ppi_pkg;

  // Register select on {a1, a0}
  localparam logic [1:0] ADDR_PA = 2'b00;
  localparam logic [1:0] ADDR_PB = 2'b01;
  localparam logic [1:0] ADDR_ST = 2'b10;
  localparam logic [1:0] ADDR_CW = 2'b11;

  // Control word bit positions
  localparam int CW_A_MODE = 0;
  localparam int CW_A_DIR  = 1;
  localparam int CW_B_MODE = 2;
  localparam int CW_B_DIR  = 3;
  localparam int CW_INTE_A = 4;
  localparam int CW_INTE_B = 5;
  localparam int CW_RSVD   = 6;
  localparam int CW_VALID  = 7;

  // Both ports mode 0, input, interrupts off
  localparam logic [7:0] CWR_RST = 8'h8A;

  // Status byte: one nibble per port, port A in the low nibble
  localparam int ST_IBF   = 0;
  localparam int ST_OBFB  = 1;
  localparam int ST_INTR  = 2;
  localparam int ST_OVR   = 3;
  localparam int ST_A_LSB = 0;
  localparam int ST_B_LSB = 4;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {I_EMPTY, I_STB, I_FULL} in_state_t;
  typedef enum logic [1:0] {O_EMPTY, O_FULL, O_ACK} out_state_t;

  // Pack one port's flags into its status nibble
  function automatic logic [3:0] st_nibble(input logic ibf, input logic obfb,
                                           input logic intr, input logic ovr);
    logic [3:0] n;
    n          = '0;
    n[ST_IBF]  = ibf;
    n[ST_OBFB] = obfb;
    n[ST_INTR] = intr;
    n[ST_OVR]  = ovr;
    return n;
  endfunction

endpackage

// File: rtl/ppi_hs_port.sv
// One peripheral port: pin/strobe synchronisers, input and output registers,
// and the mode 1 input/output handshake state machines.
module ppi_hs_port
  import ppi_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         i_mode,     // 1 = strobed handshake
  input  logic         i_dir_in,   // 1 = input
  input  logic         i_inte,
  input  logic         i_clr,      // control word write: drop handshake state
  input  logic [W-1:0] i_pins,
  input  logic         i_stbb,
  input  logic         i_ackb,
  input  logic         i_rd_fall,  // bus edges already qualified by this port's address
  input  logic         i_rd_rise,
  input  logic         i_wr_fall,
  input  logic         i_wr_rise,
  input  logic         i_ovr_clr,  // status register read completed
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_out,
  output logic [W-1:0] o_rdata,
  output logic         o_ibf,
  output logic         o_obfb,
  output logic         o_intr,
  output logic         o_ovr
);

  logic [W-1:0] r_pin_s1, r_pin_s2;
  logic         r_stb_s1, r_stb_s2, r_stb_q;
  logic         r_ack_s1, r_ack_s2, r_ack_q;
  logic         w_stb_fall, w_stb_rise, w_ack_fall, w_ack_rise;

  logic [W-1:0] r_in, r_out, w_in_nxt, w_out_nxt;
  logic         r_ibf, r_obfb, r_intr, r_ovr;
  logic         w_ibf_nxt, w_obfb_nxt, w_intr_nxt, w_ovr_nxt;
  in_state_t    r_ist, w_ist_nxt;
  out_state_t   r_ost, w_ost_nxt;

  // Two-flop synchronisers plus an edge register; strobes idle high
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_pin_s1 <= '0;
      r_pin_s2 <= '0;
      r_stb_s1 <= 1'b1;
      r_stb_s2 <= 1'b1;
      r_stb_q  <= 1'b1;
      r_ack_s1 <= 1'b1;
      r_ack_s2 <= 1'b1;
      r_ack_q  <= 1'b1;
    end else begin
      r_pin_s1 <= i_pins;
      r_pin_s2 <= r_pin_s1;
      r_stb_s1 <= i_stbb;
      r_stb_s2 <= r_stb_s1;
      r_stb_q  <= r_stb_s2;
      r_ack_s1 <= i_ackb;
      r_ack_s2 <= r_ack_s1;
      r_ack_q  <= r_ack_s2;
    end
  end

  assign w_stb_fall = r_stb_q & ~r_stb_s2;
  assign w_stb_rise = ~r_stb_q & r_stb_s2;
  assign w_ack_fall = r_ack_q & ~r_ack_s2;
  assign w_ack_rise = ~r_ack_q & r_ack_s2;

  // Handshake state and data registers
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_ist  <= I_EMPTY;
      r_ost  <= O_EMPTY;
      r_in   <= '0;
      r_out  <= '0;
      r_ibf  <= 1'b0;
      r_obfb <= 1'b1;
      r_intr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_ist  <= w_ist_nxt;
      r_ost  <= w_ost_nxt;
      r_in   <= w_in_nxt;
      r_out  <= w_out_nxt;
      r_ibf  <= w_ibf_nxt;
      r_obfb <= w_obfb_nxt;
      r_intr <= w_intr_nxt;
      r_ovr  <= w_ovr_nxt;
    end
  end

  // Next-state: input FSM applies the ibf clear before the strobe so a
  // coincident read-complete and new strobe latches cleanly; on the output
  // side a completed write outranks a coincident acknowledge.
  always_comb begin
    w_ist_nxt  = r_ist;
    w_ost_nxt  = r_ost;
    w_in_nxt   = r_in;
    w_out_nxt  = r_out;
    w_ibf_nxt  = r_ibf;
    w_obfb_nxt = r_obfb;
    w_intr_nxt = r_intr;
    w_ovr_nxt  = r_ovr;
    if (i_clr) begin
      w_ist_nxt  = I_EMPTY;
      w_ost_nxt  = O_EMPTY;
      w_out_nxt  = '0;
      w_ibf_nxt  = 1'b0;
      w_obfb_nxt = 1'b1;
      w_intr_nxt = 1'b0;
      w_ovr_nxt  = 1'b0;
    end else begin
      if (i_wr_fall) w_out_nxt = i_wdata;
      if (i_mode && i_dir_in) begin
        if (i_rd_fall) w_intr_nxt = 1'b0;
        if (i_rd_rise) begin
          w_ibf_nxt = 1'b0;
          w_ist_nxt = I_EMPTY;
        end
        if (w_stb_fall) begin
          if (w_ibf_nxt) begin
            w_ovr_nxt = 1'b1;
          end else begin
            w_in_nxt  = r_pin_s2;
            w_ibf_nxt = 1'b1;
            w_ist_nxt = I_STB;
          end
        end
        if (w_stb_rise && r_ist == I_STB) begin
          w_ist_nxt = I_FULL;
          if (i_inte) w_intr_nxt = 1'b1;
        end
      end else if (i_mode) begin
        if (i_wr_fall) begin
          w_intr_nxt = 1'b0;
          if (!r_obfb) w_ovr_nxt = 1'b1;
        end
        if (i_wr_rise) begin
          w_obfb_nxt = 1'b0;
          w_ost_nxt  = O_FULL;
        end else if (w_ack_fall && r_ost == O_FULL) begin
          w_obfb_nxt = 1'b1;
          w_ost_nxt  = O_ACK;
        end
        if (w_ack_rise && r_ost == O_ACK) begin
          w_ost_nxt = O_EMPTY;
          if (i_inte) w_intr_nxt = 1'b1;
        end
      end
      if (i_ovr_clr) w_ovr_nxt = 1'b0;
    end
  end

  // Output direction reads back the output register; mode 0 input sees the pins
  assign o_rdata = !i_dir_in ? r_out : (i_mode ? r_in : r_pin_s2);
  assign o_out   = r_out;
  assign o_ibf   = r_ibf;
  assign o_obfb  = r_obfb;
  assign o_intr  = r_intr;
  assign o_ovr   = r_ovr;

endmodule

// File: rtl/ppi_strobed.sv
// Parallel peripheral interface top: control word, bus strobe edge detection,
// address decode, read mux and tristate drivers around two handshake ports.
module ppi_strobed
  import ppi_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         rdb,
  input  logic         wrb,
  input  logic         a1,
  input  logic         a0,
  inout  wire  [W-1:0] data,
  inout  wire  [W-1:0] PA,
  inout  wire  [W-1:0] PB,
  input  logic         stbb_a,
  input  logic         stbb_b,
  input  logic         ackb_a,
  input  logic         ackb_b,
  output logic         ibf_a,
  output logic         ibf_b,
  output logic         obfb_a,
  output logic         obfb_b,
  output logic         intr_a,
  output logic         intr_b
);

  logic         r_rdb_q, r_wrb_q;
  logic [7:0]   r_cwr;
  logic [1:0]   w_addr;
  logic         w_rd_fall, w_rd_rise, w_wr_fall, w_wr_rise;
  logic         w_cw_wr, w_st_rd_rise;
  logic [W-1:0] w_rd;
  logic [7:0]   w_status;

  logic [NUM_PORTS-1:0][W-1:0] w_pins, w_out, w_rdata;
  logic [NUM_PORTS-1:0]        w_stbb, w_ackb, w_sel, w_mode, w_dir, w_inte;
  logic [NUM_PORTS-1:0]        w_ibf, w_obfb, w_intr, w_ovr;

  assign w_addr = {a1, a0};

  // Registered copies of the bus strobes for edge detection
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_rdb_q <= 1'b1;
      r_wrb_q <= 1'b1;
    end else begin
      r_rdb_q <= rdb;
      r_wrb_q <= wrb;
    end
  end

  assign w_rd_fall = r_rdb_q & ~rdb;
  assign w_rd_rise = ~r_rdb_q & rdb;
  assign w_wr_fall = r_wrb_q & ~wrb;
  assign w_wr_rise = ~r_wrb_q & wrb;

  assign w_cw_wr      = w_wr_fall && (w_addr == ADDR_CW) && data[CW_VALID];
  assign w_st_rd_rise = w_rd_rise && (w_addr == ADDR_ST);

  // Control word; writes without the valid bit are dropped
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) r_cwr <= CWR_RST;
    else if (w_cw_wr) r_cwr <= data[7:0];
  end

  assign w_sel  = {w_addr == ADDR_PB, w_addr == ADDR_PA};
  assign w_mode = {r_cwr[CW_B_MODE], r_cwr[CW_A_MODE]};
  assign w_dir  = {r_cwr[CW_B_DIR],  r_cwr[CW_A_DIR]};
  assign w_inte = {r_cwr[CW_INTE_B], r_cwr[CW_INTE_A]};

  assign w_pins[0] = PA;
  assign w_pins[1] = PB;
  assign w_stbb    = {stbb_b, stbb_a};
  assign w_ackb    = {ackb_b, ackb_a};

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    ppi_hs_port #(.W(W)) u_port (
      .clk       (clk),
      .resetb    (resetb),
      .i_mode    (w_mode[g]),
      .i_dir_in  (w_dir[g]),
      .i_inte    (w_inte[g]),
      .i_clr     (w_cw_wr),
      .i_pins    (w_pins[g]),
      .i_stbb    (w_stbb[g]),
      .i_ackb    (w_ackb[g]),
      .i_rd_fall (w_rd_fall & w_sel[g]),
      .i_rd_rise (w_rd_rise & w_sel[g]),
      .i_wr_fall (w_wr_fall & w_sel[g]),
      .i_wr_rise (w_wr_rise & w_sel[g]),
      .i_ovr_clr (w_st_rd_rise),
      .i_wdata   (data),
      .o_out     (w_out[g]),
      .o_rdata   (w_rdata[g]),
      .o_ibf     (w_ibf[g]),
      .o_obfb    (w_obfb[g]),
      .o_intr    (w_intr[g]),
      .o_ovr     (w_ovr[g])
    );
  end

  assign w_status[ST_A_LSB +: 4] = st_nibble(w_ibf[0], w_obfb[0], w_intr[0], w_ovr[0]);
  assign w_status[ST_B_LSB +: 4] = st_nibble(w_ibf[1], w_obfb[1], w_intr[1], w_ovr[1]);

  // Read mux; byte-wide registers are zero-extended to the bus width
  always_comb begin
    w_rd = '0;
    case (w_addr)
      ADDR_PA: w_rd      = w_rdata[0];
      ADDR_PB: w_rd      = w_rdata[1];
      ADDR_ST: w_rd[7:0] = w_status;
      default: w_rd[7:0] = r_cwr;
    endcase
  end

  // Buses release immediately on reset, independent of the clock
  assign data = (resetb && !rdb)      ? w_rd     : 'z;
  assign PA   = (resetb && !w_dir[0]) ? w_out[0] : 'z;
  assign PB   = (resetb && !w_dir[1]) ? w_out[1] : 'z;

  assign ibf_a  = w_ibf[0];
  assign ibf_b  = w_ibf[1];
  assign obfb_a = w_obfb[0];
  assign obfb_b = w_obfb[1];
  assign intr_a = w_intr[0];
  assign intr_b = w_intr[1];

endmodule

// File: tb/tb_ppi_strobed.sv
// Directed bench for ppi_strobed: expected values queue up as stimulus is
// applied and are compared when the DUT output is sampled.
module tb_ppi_strobed;
  localparam int W = 12;
  localparam logic [1:0] AA = 2'b00, AB = 2'b01, AS = 2'b10, AC = 2'b11;

  logic clk = 1'b0, resetb = 1'b0, rdb = 1'b1, wrb = 1'b1, a1 = 1'b0, a0 = 1'b0;
  logic stbb_a = 1'b1, stbb_b = 1'b1, ackb_a = 1'b1, ackb_b = 1'b1;
  logic ibf_a, ibf_b, obfb_a, obfb_b, intr_a, intr_b;
  wire  [W-1:0] data, PA, PB;
  logic [W-1:0] d_drv = '0, pa_drv = '0, pb_drv = '0;
  logic d_en = 1'b0, pa_en = 1'b0, pb_en = 1'b0;

  assign data = d_en  ? d_drv  : 'z;
  assign PA   = pa_en ? pa_drv : 'z;
  assign PB   = pb_en ? pb_drv : 'z;

  ppi_strobed #(.W(W)) dut (
    .clk(clk), .resetb(resetb), .rdb(rdb), .wrb(wrb), .a1(a1), .a0(a0),
    .data(data), .PA(PA), .PB(PB),
    .stbb_a(stbb_a), .stbb_b(stbb_b), .ackb_a(ackb_a), .ackb_b(ackb_b),
    .ibf_a(ibf_a), .ibf_b(ibf_b), .obfb_a(obfb_a), .obfb_b(obfb_b),
    .intr_a(intr_a), .intr_b(intr_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [W-1:0] val;
  } exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [W-1:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [W-1:0] obs);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: got %h required an entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: got %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    push(tag, W'(exp));
    pop_cmp(W'(obs));
  endtask

  task automatic rd_lo(input logic [1:0] a);
    {a1, a0} = a;
    rdb = 1'b0;
    cyc(1);
  endtask

  task automatic rd_hi();
    rdb = 1'b1;
    cyc(1);
  endtask

  task automatic bus_rd(input string tag, input logic [1:0] a, input logic [W-1:0] exp);
    push(tag, exp);
    rd_lo(a);
    pop_cmp(data);
    rd_hi();
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [W-1:0] v);
    {a1, a0} = a;
    d_drv = v;
    d_en  = 1'b1;
    wrb   = 1'b0;
    cyc(1);
    wrb = 1'b1;
    cyc(1);
    d_en = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_stbb_a();
    stbb_a = 1'b0;
    cyc(3);
    stbb_a = 1'b1;
    cyc(3);
  endtask

  initial begin
    // Reset state
    cyc(3);
    chk("rst_ibf_a", ibf_a, 1'b0);
    chk("rst_obfb_a", obfb_a, 1'b1);
    chk("rst_intr_a", intr_a, 1'b0);
    chk("rst_ibf_b", ibf_b, 1'b0);
    chk("rst_obfb_b", obfb_b, 1'b1);
    chk("rst_intr_b", intr_b, 1'b0);
    resetb = 1'b1;
    cyc(1);
    // Buses undriven by the DUT: bench patterns must read back intact
    pa_drv = 12'h05A; pa_en = 1'b1;
    pb_drv = 12'h0C3; pb_en = 1'b1;
    d_drv  = 12'h999; d_en  = 1'b1;
    #1;
    push("pa_z", 12'h05A); pop_cmp(PA);
    push("pb_z", 12'h0C3); pop_cmp(PB);
    push("data_z", 12'h999); pop_cmp(data);
    d_en = 1'b0;
    cyc(2);
    bus_rd("cwr_rst", AC, 12'h08A);
    bus_rd("a_mode0_in", AA, 12'h05A);
    bus_rd("status_rst", AS, 12'h022);

    // Mode 0 output on both ports
    pa_en = 1'b0; pb_en = 1'b0;
    bus_wr(AC, 12'hF80);
    bus_rd("cwr_upper_ignored", AC, 12'h080);
    bus_wr(AA, 12'h0BC);
    push("pa_out", 12'h0BC); pop_cmp(PA);
    push("pb_default", 12'h000); pop_cmp(PB);
    bus_wr(AC, 12'h013);
    bus_rd("cwr_no_valid_ignored", AC, 12'h080);
    push("pa_hold", 12'h0BC); pop_cmp(PA);

    // A mode 1 input with interrupt
    bus_wr(AC, 12'h093);
    pa_drv = 12'h0A5; pa_en = 1'b1;
    cyc(2);
    stbb_a = 1'b0;
    cyc(2);
    chk("ibf_a_not_yet", ibf_a, 1'b0);
    cyc(1);
    chk("ibf_a_set", ibf_a, 1'b1);
    chk("intr_a_wait_rise", intr_a, 1'b0);
    stbb_a = 1'b1;
    cyc(3);
    chk("intr_a_set", intr_a, 1'b1);
    push("rd_a", 12'h0A5);
    rd_lo(AA);
    pop_cmp(data);
    chk("intr_a_rd_fall", intr_a, 1'b0);
    chk("ibf_a_held", ibf_a, 1'b1);
    rd_hi();
    chk("ibf_a_rd_rise", ibf_a, 1'b0);

    // Overrun: second strobe while ibf is set
    pulse_stbb_a();
    pa_drv = 12'h011;
    cyc(2);
    pulse_stbb_a();
    bus_rd("status_ovr_a", AS, 12'h02F);
    bus_rd("status_ovr_cleared", AS, 12'h027);

    // Read completion and new strobe on the same edge
    {a1, a0} = AA;
    stbb_a = 1'b0;
    rdb = 1'b0;
    cyc(1);
    push("a_data_kept", 12'h0A5); pop_cmp(data);
    cyc(1);
    rdb = 1'b1;
    cyc(1);
    chk("ibf_a_coincident", ibf_a, 1'b1);
    stbb_a = 1'b1;
    cyc(3);
    bus_rd("status_no_ovr", AS, 12'h027);
    bus_rd("rd_a_new", AA, 12'h011);
    chk("ibf_a_clr2", ibf_a, 1'b0);

    // Control word write drops handshake state
    pulse_stbb_a();
    chk("ibf_a_pre_cw", ibf_a, 1'b1);
    pa_en = 1'b0;
    bus_wr(AC, 12'h0A4);
    chk("ibf_a_cw_clr", ibf_a, 1'b0);
    chk("intr_a_cw_clr", intr_a, 1'b0);
    push("pa_cleared", 12'h000); pop_cmp(PA);

    // B mode 1 output with interrupt
    bus_wr(AB, 12'h067);
    push("pb_out", 12'h067); pop_cmp(PB);
    chk("obfb_b_full", obfb_b, 1'b0);
    chk("intr_b_idle", intr_b, 1'b0);
    ackb_b = 1'b0;
    cyc(2);
    chk("obfb_b_not_yet", obfb_b, 1'b0);
    cyc(1);
    chk("obfb_b_ack", obfb_b, 1'b1);
    chk("intr_b_wait_rise", intr_b, 1'b0);
    ackb_b = 1'b1;
    cyc(3);
    chk("intr_b_set", intr_b, 1'b1);
    bus_wr(AB, 12'h0F0);
    chk("intr_b_wr_clr", intr_b, 1'b0);
    chk("obfb_b_full2", obfb_b, 1'b0);
    bus_wr(AB, 12'h0E1);
    push("pb_overwrite", 12'h0E1); pop_cmp(PB);
    bus_rd("status_ovr_b", AS, 12'h082);

    // Asynchronous reset mid-handshake
    bus_wr(AC, 12'h0B7);
    pa_drv = 12'h03C; pa_en = 1'b1;
    bus_wr(AB, 12'h055);
    chk("obfb_b_pre_rst", obfb_b, 1'b0);
    cyc(2);
    stbb_a = 1'b0;
    cyc(3);
    chk("ibf_a_pre_rst", ibf_a, 1'b1);
    {a1, a0} = AA;
    rdb = 1'b0;
    #1;
    push("data_pre_rst", 12'h03C); pop_cmp(data);
    #1;
    resetb = 1'b0;
    pb_drv = 12'h096; pb_en = 1'b1;
    d_drv  = 12'h069; d_en  = 1'b1;
    #1;
    chk("rst_async_ibf_a", ibf_a, 1'b0);
    chk("rst_async_obfb_a", obfb_a, 1'b1);
    chk("rst_async_obfb_b", obfb_b, 1'b1);
    chk("rst_async_intr_a", intr_a, 1'b0);
    chk("rst_async_intr_b", intr_b, 1'b0);
    push("rst_async_pb_z", 12'h096); pop_cmp(PB);
    push("rst_async_pa_z", 12'h03C); pop_cmp(PA);
    push("rst_async_data_z", 12'h069); pop_cmp(data);
    stbb_a = 1'b1;
    rdb = 1'b1;
    d_en = 1'b0;
    pb_en = 1'b0;
    cyc(2);
    resetb = 1'b1;
    cyc(1);
    bus_rd("cwr_after_rst", AC, 12'h08A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ppi_strobed.md
# ppi_strobed

Parametrised, clocked successor to the mode-0 parallel peripheral interface. It provides two W-bit ports, A and B, each independently configured by the control word register for one of two modes: mode 0 (simple latched I/O) or mode 1 (strobed handshake). Mode 1 adds input-buffer-full and output-buffer-full flags, per-port interrupts and overrun detection. It sits between the CPU bus and external peripherals.

## Interface
- W, default 8: width of PA, PB and the data bus; W ≥ 8.
- clk  in  1  system clock; all state updates on its rising edge.
- resetb  in  1  asynchronous, active-low reset.
- rdb, wrb  in  1 each  active-low bus read/write strobes, synchronous to clk.
- a1, a0  in  1 each  register select: 00 port A, 01 port B, 10 status, 11 control.
- data  inout  W  CPU data bus; driven only during a selected read, otherwise z.
- PA, PB  inout  W  peripheral ports; driven from the output register when the port direction is output, otherwise z.
- stbb_a, stbb_b  in  1  active-low peripheral input strobes (mode 1 input).
- ackb_a, ackb_b  in  1  active-low peripheral acknowledges (mode 1 output).
- ibf_a, ibf_b  out  1  input buffer full.
- obfb_a, obfb_b  out  1  active-low output buffer full.
- intr_a, intr_b  out  1  interrupt requests.

## Operation
- Control word (CWR[7:0]) bits:
  - bit 7 must be 1; writes with bit 7 = 0 are ignored.
  - bit 0: A mode. bit 1: A direction (1 = input).
  - bit 2: B mode. bit 3: B direction (1 = input).
  - bit 4: INTE A. bit 5: INTE B. Bit 6 is reserved and stored.
  - Upper data bits above bit 7 are ignored on write and read back as 0.
- Reset values:
  - CWR = 8'h8A (both ports mode 0, input, interrupts disabled).
  - Output registers 0, ibf 0, obfb 1, intr 0, overrun flags 0.
  - PA, PB and data are z.
- Writing CWR resets the handshake state of both ports: output register, ibf, obfb, intr and ovr all return to their reset values.
- Mode 0:
  - Input read returns the port pins after a 2-flop synchroniser.
  - Output drives the output register continuously. This changes the previous behaviour, where the port was driven only while wrb was low.
- Mode 1 input, FSM per port I_EMPTY → I_STB → I_FULL:
  - stbb falling edge: latch the pins into the input register, set ibf=1, state I_STB.
  - stbb rising edge: state I_FULL; set intr if INTE.
  - rdb falling edge on the port address: clear intr.
  - rdb rising edge on the port address: clear ibf, return to I_EMPTY.
  - stbb falling edge while ibf=1: data is dropped and ovr is set.
- Mode 1 output, FSM per port O_EMPTY → O_FULL → O_ACK:
  - wrb falling edge on the port address: load the output register and clear intr.
  - wrb rising edge: obfb=0, state O_FULL.
  - ackb falling edge: obfb=1, state O_ACK.
  - ackb rising edge: set intr if INTE, return to O_EMPTY.
  - Write while obfb=0: the output register is overwritten and ovr is set.
- Status register, read at address 10, zero-extended to W:
  - bits {ovr_b, intr_b, obfb_b, ibf_b, ovr_a, intr_a, obfb_a, ibf_a}, bit 7 down to bit 0.
  - rdb rising edge on the status address clears both ovr flags.
- Reading address 11 returns CWR.

## Timing
- Bus strobe edges:
  - A falling edge is detected at the first clk edge where the strobe is 0 and its registered copy is 1; a rising edge is the inverse.
  - The action takes effect on that same clk edge.
  - Write data is sampled on the wrb-falling detection edge.
  - rdb and wrb each need at least 1 clk low and 1 clk high.
- Read data is combinational from the registers while rdb=0 and the address selects a register. The input register is stable during a read.
- stbb and ackb pass through 2-flop synchronisers plus an edge register. Flag and FSM updates occur on the 3rd clk edge after the pin transition.
- Simultaneous events:
  - ibf clear and stbb falling in the same cycle: the clear is applied first, so the new data is latched, ibf=1 and no overrun.
  - wrb rising and ackb falling in the same cycle: wrb wins, obfb=0, state O_FULL.
- Asynchronous reset mid-operation immediately restores all reset values and tristates all buses, regardless of FSM state.

## Structure
- Package ppi_pkg holds:
  - address constants;
  - CWR bit indices and the CWR reset value 8'h8A;
  - status bit indices;
  - FSM state typedefs for the input and output state machines.
- Sub-module ppi_hs_port, instantiated twice (A and B), contains:
  - the synchronisers and edge detectors;
  - the input and output registers;
  - the two FSMs and the ibf/obfb/intr/ovr logic.
- The top level holds CWR, bus edge detection, address decode, read mux and tristate control.

## Test plan
- Reset, then read address 11 → 8'h8A. PA, PB and data are z; obfb_a=1, ibf_a=0.
- Write CWR 8'h80 (both mode 0 output), write A=8'hBC → PA=8'hBC continuously after wrb rises. B defaults to 0.
- Write CWR 8'h93 (A mode 1 input, INTE A). Drive PA=8'hA5 and pulse stbb_a → 3 clk later ibf_a=1; intr_a=1 after stbb rises. Read A → 8'hA5; intr_a clears on rdb falling, ibf_a clears on rdb rising.
- A mode 1 input with ibf_a=1: second stbb_a pulse with PA=8'h11 → data stays 8'hA5, status bit 3 = 1. A status read clears it.
- Write CWR 8'hA4 (B mode 1 output, INTE B). Write B=8'h67 → PB=8'h67, obfb_b=0. Pulse ackb_b → obfb_b=1, then intr_b=1. A second write clears intr_b.
- Assert resetb low mid-handshake (ibf_a=1, obfb_b=0) → all outputs return to their reset values at once and the buses go z.
